// File: rtl/uart_tx_buf.sv
// UART transmitter with a small byte FIFO in front of a start/data/stop framing FSM.
// Define UART_TX_PARITY_EN to insert an even-parity bit after D7 (11-bit frames).
module uart_tx_buf #(
   parameter int unsigned DIV_RATE   = 260,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   output logic       full,
   output logic       tx_busy,
   output logic       tx_end,
   output logic       tx
);

   localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW  = AddrW + 1;
   localparam int unsigned DivW  = $clog2(DIV_RATE);

   localparam logic [DivW-1:0] DivLoad  = DivW'(DIV_RATE - 1);
   localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } state_e;

   // ---------------------------------------------------------------------------
   // Transmit FIFO
   // ---------------------------------------------------------------------------
   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [AddrW-1:0] wr_ptr_q;
   logic [AddrW-1:0] rd_ptr_q;
   logic [CntW-1:0]  count_q;
   logic [CntW-1:0]  count_d;
   logic             full_q;
   logic             push;
   logic             pop;
   logic [7:0]       head;

   // A write while full is dropped even if a pop frees a slot in the same cycle.
   assign push = wr_en & ~full_q;
   assign head = mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_d;
         full_q  <= (count_d == DepthCnt);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !reset) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Framing state machine
   // ---------------------------------------------------------------------------
   state_e          state_q;
   logic [DivW-1:0] div_cnt_q;
   logic [2:0]      bit_cnt_q;
   logic [7:0]      shift_q;
   logic            tx_q;
   logic            tx_end_q;
   logic            bit_done;
`ifdef UART_TX_PARITY_EN
   logic            parity_q;
`endif

   assign bit_done = (div_cnt_q == '0);
   assign pop      = (count_q != '0) &&
                     ((state_q == StIdle) || ((state_q == StStop) && bit_done));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         div_cnt_q <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
         tx_end_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         tx_end_q <= 1'b0;
         case (state_q)
            StIdle: begin
               tx_q <= 1'b1;
            end
            StStart: begin
               if (!bit_done) begin
                  div_cnt_q <= div_cnt_q - 1'b1;
               end else begin
                  tx_q      <= shift_q[0];
                  shift_q   <= {1'b0, shift_q[7:1]};
                  bit_cnt_q <= '0;
                  div_cnt_q <= DivLoad;
                  state_q   <= StData;
               end
            end
            StData: begin
               if (!bit_done) begin
                  div_cnt_q <= div_cnt_q - 1'b1;
               end else if (bit_cnt_q == 3'd7) begin
                  div_cnt_q <= DivLoad;
                  bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
                  tx_q      <= parity_q;
                  state_q   <= StParity;
`else
                  tx_q      <= 1'b1;
                  state_q   <= StStop;
`endif
               end else begin
                  tx_q      <= shift_q[0];
                  shift_q   <= {1'b0, shift_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  div_cnt_q <= DivLoad;
               end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
               if (!bit_done) begin
                  div_cnt_q <= div_cnt_q - 1'b1;
               end else begin
                  tx_q      <= 1'b1;
                  div_cnt_q <= DivLoad;
                  state_q   <= StStop;
               end
            end
`endif
            StStop: begin
               if (!bit_done) begin
                  div_cnt_q <= div_cnt_q - 1'b1;
               end else begin
                  tx_end_q <= 1'b1;
                  tx_q     <= 1'b1;
                  state_q  <= StIdle;
               end
            end
            default: begin
               tx_q    <= 1'b1;
               state_q <= StIdle;
            end
         endcase

         // Loading the next byte overrides the idle/stop defaults above, so a queued
         // byte starts straight after the stop bit with no idle cycle.
         if (pop) begin
            shift_q   <= head;
            tx_q      <= 1'b0;
            div_cnt_q <= DivLoad;
            state_q   <= StStart;
`ifdef UART_TX_PARITY_EN
            parity_q  <= ^head;
`endif
         end
      end
   end

   assign full    = full_q;
   assign tx      = tx_q;
   assign tx_end  = tx_end_q;
   assign tx_busy = (state_q != StIdle) || (count_q != '0);

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed self-checking bench for uart_tx_buf with DIV_RATE=4, FIFO_DEPTH=4.
// Frame checks follow UART_TX_PARITY_EN (10-bit frames without it, 11-bit with it).
module tb_uart_tx_buf;

   localparam int DIV   = 4;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       full;
   logic       tx_busy;
   logic       tx_end;
   logic       tx;

   int errors = 0;
   int checks = 0;
   int end_cnt = 0;

   uart_tx_buf #(
      .DIV_RATE   (DIV),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .full    (full),
      .tx_busy (tx_busy),
      .tx_end  (tx_end),
      .tx      (tx)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!reset && tx_end === 1'b1) end_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called one step after the edge where tx fell for the start bit; returns one step
   // after the edge that ends the stop bit.
   task automatic check_frame(input logic [7:0] data, input string name);
      logic [NBITS-1:0] bits;
      logic [DIV-1:0]   seen;
      int               early;
      early = 0;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = data[i];
`ifdef UART_TX_PARITY_EN
      bits[9] = ^data;
`endif
      bits[NBITS-1] = 1'b1;
      for (int b = 0; b < NBITS; b++) begin
         for (int c = 0; c < DIV; c++) begin
            seen[c] = tx;
            // The first cycle of a back-to-back frame overlaps the previous tx_end pulse.
            if (!(b == 0 && c == 0) && tx_end !== 1'b0) early++;
            tick();
         end
         checks++;
         if (seen !== {DIV{bits[b]}}) begin
            errors++;
            $display("FAIL %s bit%0d: tx samples=%b required=%b", name, b, seen,
                     {DIV{bits[b]}});
         end
      end
      checks++;
      if (early !== 0) begin
         errors++;
         $display("FAIL %s early_tx_end: %0d stray cycles, required 0", name, early);
      end
      checks++;
      if (tx_end !== 1'b1) begin
         errors++;
         $display("FAIL %s tx_end_at_stop: got %b required 1", name, tx_end);
      end
   endtask

   task automatic test_reset();
      wr_en = 1'b1;
      wr_data = 8'hAA;
      repeat (3) tick();
      checks++;
      if (tx !== 1'b1) begin
         errors++;
         $display("FAIL reset_tx_during: got %b required 1", tx);
      end
      wr_en = 1'b0;
      reset = 1'b0;
      tick();
      checks++;
      if (tx !== 1'b1) begin
         errors++;
         $display("FAIL reset_tx: got %b required 1", tx);
      end
      checks++;
      if (full !== 1'b0) begin
         errors++;
         $display("FAIL reset_full: got %b required 0", full);
      end
      checks++;
      if (tx_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy: got %b required 0", tx_busy);
      end
      checks++;
      if (tx_end !== 1'b0) begin
         errors++;
         $display("FAIL reset_tx_end: got %b required 0", tx_end);
      end
      repeat (6) tick();
      checks++;
      if ({tx, tx_busy} !== 2'b10) begin
         errors++;
         $display("FAIL reset_write_ignored: tx,busy=%b required 10", {tx, tx_busy});
      end
   endtask

   task automatic test_single();
      end_cnt = 0;
      wr_data = 8'h55;
      wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
      checks++;
      if (tx !== 1'b1) begin
         errors++;
         $display("FAIL single_latency_k1: tx=%b required 1", tx);
      end
      checks++;
      if (tx_busy !== 1'b1) begin
         errors++;
         $display("FAIL single_busy: got %b required 1", tx_busy);
      end
      tick();
      checks++;
      if (tx !== 1'b0) begin
         errors++;
         $display("FAIL single_latency_k2: tx=%b required 0", tx);
      end
      check_frame(8'h55, "single");
      checks++;
      if ({tx, tx_busy} !== 2'b10) begin
         errors++;
         $display("FAIL single_idle_after: tx,busy=%b required 10", {tx, tx_busy});
      end
      tick();
      checks++;
      if (tx_end !== 1'b0) begin
         errors++;
         $display("FAIL single_pulse_width: tx_end=%b required 0", tx_end);
      end
      checks++;
      if (end_cnt !== 1) begin
         errors++;
         $display("FAIL single_end_count: got %0d required 1", end_cnt);
      end
   endtask

   task automatic test_back_to_back();
      end_cnt = 0;
      wr_data = 8'hA3;
      wr_en = 1'b1;
      tick();
      wr_data = 8'h0F;
      tick();
      wr_en = 1'b0;
      checks++;
      if (tx !== 1'b0) begin
         errors++;
         $display("FAIL b2b_start: tx=%b required 0", tx);
      end
      check_frame(8'hA3, "b2b_first");
      checks++;
      if (tx !== 1'b0) begin
         errors++;
         $display("FAIL b2b_no_gap: tx=%b required 0", tx);
      end
      check_frame(8'h0F, "b2b_second");
      checks++;
      if (tx_busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_busy_after: got %b required 0", tx_busy);
      end
      tick();
      checks++;
      if (end_cnt !== 2) begin
         errors++;
         $display("FAIL b2b_end_count: got %0d required 2", end_cnt);
      end
   endtask

   task automatic test_full();
      logic [7:0] sb[$];
      logic [4:0] exp_full;
      int         waited;
      int         low_cycles;
      exp_full = 5'b11000;
      end_cnt = 0;
      wr_data = 8'hC3;
      wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
      sb.push_back(8'hC3);
      tick();
      repeat (6) tick();
      // C3 is in the shifter, so none of these writes meets a pop.
      for (int i = 0; i < 5; i++) begin
         wr_data = 8'(i + 1);
         wr_en = 1'b1;
         tick();
         if (i < DEPTH) sb.push_back(8'(i + 1));
         checks++;
         if (full !== exp_full[i]) begin
            errors++;
            $display("FAIL full_after_wr%0d: got %b required %b", i + 1, full, exp_full[i]);
         end
      end
      wr_en = 1'b0;
      waited = 0;
      while (tx_end !== 1'b1 && waited < 200) begin
         tick();
         waited++;
      end
      checks++;
      if (waited >= 200) begin
         errors++;
         $display("FAIL full_wait_first_end: timed out after %0d cycles, required < 200",
                  waited);
      end
      void'(sb.pop_front());
      checks++;
      if ({tx, full} !== 2'b00) begin
         errors++;
         $display("FAIL full_after_pop: tx,full=%b required 00", {tx, full});
      end
      while (sb.size() != 0) begin
         logic [7:0] b;
         b = sb.pop_front();
         check_frame(b, $sformatf("queued_%02h", b));
      end
      low_cycles = 0;
      repeat (60) begin
         if (tx !== 1'b1) low_cycles++;
         tick();
      end
      checks++;
      if (low_cycles !== 0) begin
         errors++;
         $display("FAIL full_dropped_byte: tx low %0d cycles, required 0", low_cycles);
      end
      checks++;
      if (end_cnt !== 5) begin
         errors++;
         $display("FAIL full_end_count: got %0d required 5", end_cnt);
      end
   endtask

   task automatic test_reset_mid_frame();
      int low_cycles;
      int busy_cycles;
      wr_data = 8'hFF;
      wr_en = 1'b1;
      tick();
      wr_data = 8'h11;
      tick();
      wr_data = 8'h22;
      tick();
      wr_en = 1'b0;
      // Start bit began one cycle ago; 16 more edges put the line in D3.
      repeat (16) tick();
      checks++;
      if ({tx, tx_busy, full} !== 3'b110) begin
         errors++;
         $display("FAIL midrst_before: tx,busy,full=%b required 110", {tx, tx_busy, full});
      end
      end_cnt = 0;
      reset = 1'b1;
      tick();
      checks++;
      if ({tx, tx_busy, full, tx_end} !== 4'b1000) begin
         errors++;
         $display("FAIL midrst_after: tx,busy,full,end=%b required 1000",
                  {tx, tx_busy, full, tx_end});
      end
      reset = 1'b0;
      low_cycles = 0;
      busy_cycles = 0;
      repeat (80) begin
         tick();
         if (tx !== 1'b1) low_cycles++;
         if (tx_busy !== 1'b0) busy_cycles++;
      end
      checks++;
      if (low_cycles !== 0) begin
         errors++;
         $display("FAIL midrst_no_frames: tx low %0d cycles, required 0", low_cycles);
      end
      checks++;
      if (busy_cycles !== 0) begin
         errors++;
         $display("FAIL midrst_busy: busy %0d cycles, required 0", busy_cycles);
      end
      checks++;
      if (end_cnt !== 0) begin
         errors++;
         $display("FAIL midrst_no_tx_end: got %0d required 0", end_cnt);
      end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      logic [7:0] vals [2];
      vals[0] = 8'h07;
      vals[1] = 8'h03;
      for (int i = 0; i < 2; i++) begin
         wr_data = vals[i];
         wr_en = 1'b1;
         tick();
         wr_en = 1'b0;
         tick();
         checks++;
         if (tx !== 1'b0) begin
            errors++;
            $display("FAIL parity_start_%02h: tx=%b required 0", vals[i], tx);
         end
         check_frame(vals[i], $sformatf("parity_%02h", vals[i]));
         repeat (3) tick();
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_full();
      test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_buf.md
UART_TX_BUF -- requirements
Module: uart_tx_buf

Interface
REQ-001 Parameter DIV_RATE, 260, clocks per UART bit period; legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, 4, transmit FIFO entries; power of two, at least 2.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 wr_en  input  1  write strobe; pushes wr_data into FIFO when full=0.
REQ-006 wr_data  input  8  byte to transmit.
REQ-007 full  output  1  FIFO holds FIFO_DEPTH entries; registered.
REQ-008 tx_busy  output  1  high when state != IDLE or FIFO not empty.
REQ-009 tx_end  output  1  one-cycle pulse on completion of each stop bit.
REQ-010 tx  output  1  UART serial line; idle high; registered.

Function
REQ-011 Frame SHALL be: start bit (0), D0..D7 LSB first, optional parity (REQ-030), stop bit (1).
REQ-012 Every bit, including start and stop, SHALL drive tx for exactly DIV_RATE clock cycles.
REQ-013 State machine SHALL have states IDLE, START, DATA, PARITY, STOP; PARITY is reachable only when UART_TX_PARITY_EN is defined.
REQ-014 IDLE: tx=1. When FIFO is non-empty, the next edge pops the head into the shift register, sets tx=0, loads div_cnt=DIV_RATE-1, and enters START.
REQ-015 A bit ends when div_cnt=0. Otherwise div_cnt decrements every cycle.
REQ-016 START->DATA at bit end. DATA shifts the register right, drives D0..D7 in turn, and counts 8 bits with a 3-bit counter.
REQ-017 Leaving DATA after D7 SHALL go to PARITY if enabled, else STOP. PARITY->STOP at bit end.
REQ-018 At STOP bit end, tx_end=1 for one cycle. If the FIFO is non-empty, the FSM pops the next byte and enters START in the same edge, giving no idle gap. Otherwise it enters IDLE.
REQ-019 Latency: wr_en at edge k into an empty FIFO with FSM in IDLE -> tx falls at edge k+2.
REQ-020 wr_en while full=1 SHALL be ignored: no pointer change and no data corruption. This holds even if a pop occurs in the same cycle.
REQ-021 Simultaneous push and pop when the FIFO is not full SHALL keep the occupancy count unchanged.
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH. The occupancy counter SHALL be log2(FIFO_DEPTH)+1 bits.
REQ-023 div_cnt width SHALL be the minimum width holding DIV_RATE-1, with no truncation warnings.
REQ-024 tx_busy SHALL fall in the same cycle that the FSM enters IDLE with the FIFO empty.

Reset
REQ-025 On reset: state=IDLE, tx=1, tx_end=0, full=0, tx_busy=0, FIFO empty, div_cnt=0, bit counter=0.
REQ-026 Reset mid-frame SHALL abort the frame, force tx=1 at the next edge, and discard all FIFO contents; no tx_end pulse is issued.
REQ-027 wr_en asserted during reset SHALL be ignored.

Configuration
REQ-028 Macro UART_TX_PARITY_EN selects parity generation.
REQ-029 Without the macro: 10-bit frame, no PARITY state logic synthesized.
REQ-030 With the macro: 11-bit frame. The parity bit equals even parity (XOR of D0..D7), is sent after D7 for DIV_RATE cycles, and is computed from the popped byte at pop time.

Verification (DIV_RATE=4, FIFO_DEPTH=4)
REQ-031 Write 0x55 when idle -> tx falls at edge k+2; bits 0,1,0,1,0,1,0,1,0,1 each 4 cycles; tx_end pulses once; tx_busy low after the stop bit.
REQ-032 Write 0xA3, 0x0F back-to-back -> two frames; the stop bit of the first is immediately followed by the start of the second, with no idle cycle; two tx_end pulses.
REQ-033 Write 5 bytes 0x01..0x05 in 5 consecutive cycles -> full asserts after the 4th accepted write; the 5th write is dropped (it coincides with no pop, since the first pop occurs earlier and frees only one slot); the exact transmitted sequence is checked against a scoreboard.
REQ-034 Assert reset during D3 of 0xFF with 2 bytes queued -> tx=1 next edge; full=0; tx_busy=0; no further frames; no tx_end.
REQ-035 With UART_TX_PARITY_EN, send 0x07 -> parity bit=1; send 0x03 -> parity bit=0; frame length 44 cycles each.
